cmp_serial: RTL

CMP_SERIAL -- requirements
Module: cmp_serial

---
 rtl/cmp_serial.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cmp_serial.sv
// Serial magnitude comparator: scans two latched operands 2 bits per cycle, MSB slice first.
// Signed mode flips both sign bits at latch time so the same unsigned slice scan applies.
module cmp_serial #(
  parameter int unsigned DATALEN    = 16,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [DATALEN-1:0] A,
  input  logic [DATALEN-1:0] B,
  output logic               busy,
  output logic               done,
  output logic               equal,
  output logic               more,
  output logic               less
);

  localparam int unsigned NumSlices = DATALEN / 2;
  localparam int unsigned IdxW      = $clog2(NumSlices);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSlices - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [DATALEN-1:0] a_q, a_d, b_q, b_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               found_q, found_d;
  logic               gt_q, gt_d;
  logic               equal_q, equal_d;
  logic               more_q, more_d;
  logic               less_q, less_d;

  logic [DATALEN-1:0] a_sh, b_sh;
  logic [1:0]         slice_a, slice_b;
  logic               slice_diff;
  logic               finish;
  logic               accept;
  logic [DATALEN-1:0] sign_flip;

  assign a_sh       = a_q >> {idx_q, 1'b0};
  assign b_sh       = b_q >> {idx_q, 1'b0};
  assign slice_a    = a_sh[1:0];
  assign slice_b    = b_sh[1:0];
  assign slice_diff = (slice_a != slice_b);
  assign finish     = (idx_q == '0) || ((EARLY_EXIT != 0) && slice_diff);
  assign accept     = start && (state_q != StRun);
  assign sign_flip  = {signed_mode, {(DATALEN-1){1'b0}}};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (finish) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Datapath next state; the first differing slice decides, later slices are ignored
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    found_d = found_q;
    gt_d    = gt_q;
    equal_d = equal_q;
    more_d  = more_q;
    less_d  = less_q;
    if (accept) begin
      a_d     = A ^ sign_flip;
      b_d     = B ^ sign_flip;
      idx_d   = LastIdx;
      found_d = 1'b0;
      gt_d    = 1'b0;
    end else if (state_q == StRun) begin
      if (!found_q && slice_diff) begin
        found_d = 1'b1;
        gt_d    = (slice_a > slice_b);
      end
      if (finish) begin
        equal_d = !(found_q || slice_diff);
        more_d  = found_q ? gt_q  : (slice_diff && (slice_a > slice_b));
        less_d  = found_q ? !gt_q : (slice_diff && (slice_a < slice_b));
      end else begin
        idx_d = idx_q - IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
      gt_q    <= 1'b0;
      equal_q <= 1'b0;
      more_q  <= 1'b0;
      less_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      found_q <= found_d;
      gt_q    <= gt_d;
      equal_q <= equal_d;
      more_q  <= more_d;
      less_q  <= less_d;
    end
  end

  assign equal = equal_q;
  assign more  = more_q;
  assign less  = less_q;

endmodule
